// File: rtl/sim_run_pkg.sv
// ---------------------------------------------------------------------------
// sim_run_pkg
// Shared definitions for the simulation run-control sequencer:
//   - run_state_e : FSM state encodings, also exported on run_state
//   - CNT_NEVER   : all-ones "never" marker for cycle-compare inputs
//                   (truncate to the counter width where used)
//   - SETTLE_CYC_DEF / LOAD_TMO_DEF : default timing parameters
//   - cnt_w_of()  : width of a counter that must hold 0..n-1
// ---------------------------------------------------------------------------
package sim_run_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_RDY = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_LOAD     = 3'd2,
      ST_RUN      = 3'd3,
      ST_DONE     = 3'd4
   } run_state_e;

   // Wide enough for any sensible CNT_W; all-ones survives truncation.
   localparam logic [63:0] CNT_NEVER = '1;

   localparam int unsigned SETTLE_CYC_DEF = 4;
   localparam int unsigned LOAD_TMO_DEF   = 1024;

   // Counter width for values 0..n-1, never less than one bit.
   function automatic int unsigned cnt_w_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sim_run_ctl_if.sv
// ---------------------------------------------------------------------------
// sim_run_ctl_if
// IMEM preload handshake between the run controller and the IMEM loader.
//   load_req : level, held by the controller while the preload is wanted
//   load_ack : one-cycle pulse from the loader when the preload is complete
// Modports:
//   master : run controller side (drives load_req)
//   slave  : loader side (drives load_ack)
// ---------------------------------------------------------------------------
interface sim_run_ctl_if;

   logic load_req;
   logic load_ack;

   modport master (
      output load_req,
      input  load_ack
   );

   modport slave (
      input  load_req,
      output load_ack
   );

endinterface

// File: rtl/sim_dump_win.sv
// ---------------------------------------------------------------------------
// sim_dump_win
// Waveform dump window: opens when the cycle counter hits the start cycle,
// closes when it hits the stop cycle, and can be forced closed.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   cycle_count_i       : current cycle number
//   cfg_startdump_i     : cycle at which the window opens (all-ones = never)
//   cfg_stopdump_i      : cycle at which the window closes (all-ones = never)
//   force_off_i         : close the window now and keep it closed
//   dump_on_o           : registered window state
//   dump_toggle_o       : registered one-cycle pulse on every dump_on_o change
// ---------------------------------------------------------------------------
module sim_dump_win
   import sim_run_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] cycle_count_i,
   input  logic [CNT_W-1:0] cfg_startdump_i,
   input  logic [CNT_W-1:0] cfg_stopdump_i,
   input  logic             force_off_i,
   output logic             dump_on_o,
   output logic             dump_toggle_o
);

   localparam logic [CNT_W-1:0] NEVER = CNT_W'(CNT_NEVER);

   logic dump_q, dump_d;
   logic tog_q, tog_d;
   logic open_now, close_now;

   // A window whose start equals its stop is empty: it never opens, so no
   // pulse is ever produced for it.
   assign open_now  = !dump_q && !force_off_i
                      && (cycle_count_i == cfg_startdump_i)
                      && (cfg_startdump_i != NEVER)
                      && (cfg_startdump_i != cfg_stopdump_i);

   assign close_now = dump_q
                      && (force_off_i
                          || ((cycle_count_i == cfg_stopdump_i) && (cfg_stopdump_i != NEVER)));

   always_comb begin
      dump_d = dump_q;
      tog_d  = 1'b0;
      if (open_now) begin
         dump_d = 1'b1;
         tog_d  = 1'b1;
      end else if (close_now) begin
         dump_d = 1'b0;
         tog_d  = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dump_q <= 1'b0;
         tog_q  <= 1'b0;
      end else begin
         dump_q <= dump_d;
         tog_q  <= tog_d;
      end
   end

   assign dump_on_o     = dump_q;
   assign dump_toggle_o = tog_q;

endmodule

// File: rtl/sim_run_ctl.sv
// ---------------------------------------------------------------------------
// sim_run_ctl
// Run-control sequencer for the simulation top level. Counts cycles from
// reset, waits for system_ready plus a settle delay, optionally runs the
// IMEM preload handshake, controls the dump window and raises a sticky
// finish at the programmed cycle limit.
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   system_ready     : level, high once reset sequencing is complete
//   cfg_load_imem    : static, 1 = perform the IMEM preload step
//   cfg_cyclelimit   : finish cycle (all-ones = never)
//   cfg_startdump    : dump-on cycle (all-ones = never)
//   cfg_stopdump     : dump-off cycle (all-ones = never)
//   ld               : preload handshake (load_req out, load_ack in)
//   cycle_count      : current cycle number, saturating, frozen once done
//   dump_on          : dump window open
//   dump_toggle      : one-cycle pulse on every dump_on change
//   finish           : sticky, simulation must end
//   load_err         : sticky, preload timed out
//   run_state        : FSM state encoding for monitors
// ---------------------------------------------------------------------------
module sim_run_ctl
   import sim_run_pkg::*;
#(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int unsigned LOAD_TMO   = LOAD_TMO_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             system_ready,
   input  logic             cfg_load_imem,
   input  logic [CNT_W-1:0] cfg_cyclelimit,
   input  logic [CNT_W-1:0] cfg_startdump,
   input  logic [CNT_W-1:0] cfg_stopdump,
   sim_run_ctl_if.master    ld,
   output logic [CNT_W-1:0] cycle_count,
   output logic             dump_on,
   output logic             dump_toggle,
   output logic             finish,
   output logic             load_err,
   output logic [2:0]       run_state
);

   localparam logic [CNT_W-1:0] NEVER    = CNT_W'(CNT_NEVER);
   localparam int unsigned      SET_W    = cnt_w_of(SETTLE_CYC);
   localparam int unsigned      TMO_W    = cnt_w_of(LOAD_TMO);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TMO - 1);

   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SET_W-1:0] set_q, set_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             load_req_q, load_req_d;
   logic             finish_q, finish_d;
   logic             load_err_q, load_err_d;
   logic             finish_hit;
   logic             force_off;

   assign finish_hit = (cnt_q == cfg_cyclelimit) && (cfg_cyclelimit != NEVER);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      set_d      = set_q;
      tmo_d      = tmo_q;
      load_req_d = load_req_q;
      finish_d   = finish_q;
      load_err_d = load_err_q;

      // The counter also holds on the finishing edge so it freezes at the
      // limit value rather than one past it.
      if ((state_q != ST_DONE) && !finish_hit && (cnt_q != NEVER)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (state_q == ST_DONE) begin
         load_req_d = 1'b0;
      end else if (finish_hit) begin
         // Beats every other transition, including an ack this cycle.
         state_d    = ST_DONE;
         finish_d   = 1'b1;
         load_req_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_WAIT_RDY: begin
               if (system_ready) begin
                  state_d = ST_SETTLE;
                  set_d   = '0;
               end
            end
            ST_SETTLE: begin
               if (!system_ready) begin
                  state_d = ST_WAIT_RDY;
               end else if (set_q == SET_LAST) begin
                  if (cfg_load_imem) begin
                     state_d    = ST_LOAD;
                     load_req_d = 1'b1;
                     tmo_d      = '0;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  set_d = set_q + SET_W'(1);
               end
            end
            ST_LOAD: begin
               if (!system_ready) begin
                  state_d    = ST_WAIT_RDY;
                  load_req_d = 1'b0;
               end else if (ld.load_ack) begin
                  state_d    = ST_RUN;
                  load_req_d = 1'b0;
               end else if (tmo_q == TMO_LAST) begin
                  state_d    = ST_RUN;
                  load_req_d = 1'b0;
                  load_err_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d    = ST_WAIT_RDY;
               load_req_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_WAIT_RDY;
         cnt_q      <= '0;
         set_q      <= '0;
         tmo_q      <= '0;
         load_req_q <= 1'b0;
         finish_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         set_q      <= set_d;
         tmo_q      <= tmo_d;
         load_req_q <= load_req_d;
         finish_q   <= finish_d;
         load_err_q <= load_err_d;
      end
   end

   // Close the window on the same edge that enters DONE, so the dump stops
   // together with finish.
   assign force_off = (state_d == ST_DONE);

   sim_dump_win #(
      .CNT_W (CNT_W)
   ) u_dump_win (
      .clock           (clock),
      .reset           (reset),
      .cycle_count_i   (cnt_q),
      .cfg_startdump_i (cfg_startdump),
      .cfg_stopdump_i  (cfg_stopdump),
      .force_off_i     (force_off),
      .dump_on_o       (dump_on),
      .dump_toggle_o   (dump_toggle)
   );

   assign ld.load_req = load_req_q;
   assign cycle_count = cnt_q;
   assign finish      = finish_q;
   assign load_err    = load_err_q;
   assign run_state   = state_q;

endmodule

// File: tb/tb_sim_run_ctl.sv
// ---------------------------------------------------------------------------
// tb_sim_run_ctl
// Self-checking bench for sim_run_ctl. An 8-bit counter is used so that
// saturation is reachable. The reference model tracks time in edges since
// reset and derives the counter, finish and dump window from arithmetic on
// that count; sequencing uses entry timestamps rather than counters.
// ---------------------------------------------------------------------------
module tb_sim_run_ctl;

   localparam int CW     = 8;
   localparam int NEV    = 255;
   localparam int SETTLE = 4;
   localparam int TMO    = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          system_ready = 1'b0;
   logic          cfg_load_imem = 1'b0;
   logic [CW-1:0] cfg_cyclelimit = 8'hFF;
   logic [CW-1:0] cfg_startdump = 8'hFF;
   logic [CW-1:0] cfg_stopdump = 8'hFF;
   logic [CW-1:0] cycle_count;
   logic          dump_on, dump_toggle, finish, load_err;
   logic [2:0]    run_state;

   sim_run_ctl_if ld_if();

   sim_run_ctl #(
      .CNT_W      (CW),
      .SETTLE_CYC (SETTLE),
      .LOAD_TMO   (TMO)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .system_ready   (system_ready),
      .cfg_load_imem  (cfg_load_imem),
      .cfg_cyclelimit (cfg_cyclelimit),
      .cfg_startdump  (cfg_startdump),
      .cfg_stopdump   (cfg_stopdump),
      .ld             (ld_if),
      .cycle_count    (cycle_count),
      .dump_on        (dump_on),
      .dump_toggle    (dump_toggle),
      .finish         (finish),
      .load_err       (load_err),
      .run_state      (run_state)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_edges = 0;     // edges since the last reset edge
   int m_t     = 0;     // edge index at which the current phase began
   int m_state = 0;     // 0 wait, 1 settle, 2 load, 3 run, 4 done
   int m_before;
   bit m_req = 0, m_err = 0, m_rst_edge = 0, m_valid = 0, prev_dump = 0;
   bit e_fin, e_dump;

   function automatic int exp_count(input int e);
      int c;
      c = (e > NEV) ? NEV : e;
      if ((int'(cfg_cyclelimit) != NEV) && (c > int'(cfg_cyclelimit))) c = int'(cfg_cyclelimit);
      return c;
   endfunction

   // Window is open for counter values in (start, stop]; if stop lies
   // before start it never closes.
   function automatic bit exp_dump_f(input int c, input bit fin);
      int s, p;
      s = int'(cfg_startdump);
      p = int'(cfg_stopdump);
      if (fin || s == NEV || s == p) return 1'b0;
      return (c > s) && ((p < s) || (c <= p));
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_edges = 0; m_state = 0; m_req = 0; m_err = 0;
         m_rst_edge = 1; m_valid = 1;
      end else if (m_valid) begin
         m_before = exp_count(m_edges);
         m_rst_edge = 0;
         m_edges++;
         if (m_state != 4) begin
            if ((int'(cfg_cyclelimit) != NEV) && (m_before == int'(cfg_cyclelimit))) begin
               m_state = 4; m_req = 0;
            end else if (m_state == 0) begin
               if (system_ready) begin m_state = 1; m_t = m_edges; end
            end else if (m_state == 1) begin
               if (!system_ready) m_state = 0;
               else if (m_edges - m_t == SETTLE) begin
                  if (cfg_load_imem) begin m_state = 2; m_req = 1; m_t = m_edges; end
                  else m_state = 3;
               end
            end else if (m_state == 2) begin
               if (!system_ready) begin m_state = 0; m_req = 0; end
               else if (ld_if.load_ack) begin m_state = 3; m_req = 0; end
               else if (m_edges - m_t == TMO) begin m_state = 3; m_req = 0; m_err = 1; end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clock) begin
      #1;
      if (m_valid) begin
         e_fin  = (int'(cfg_cyclelimit) != NEV) && (m_edges > int'(cfg_cyclelimit));
         e_dump = exp_dump_f(exp_count(m_edges), e_fin);
         check("cycle_count", 32'(cycle_count), 32'(exp_count(m_edges)));
         check("finish", 32'(finish), 32'(e_fin));
         check("run_state", 32'(run_state), 32'(m_state));
         check("load_req", 32'(ld_if.load_req), 32'(m_req));
         check("load_err", 32'(load_err), 32'(m_err));
         check("dump_on", 32'(dump_on), 32'(e_dump));
         check("dump_toggle", 32'(dump_toggle), 32'(!m_rst_edge && (e_dump != prev_dump)));
         prev_dump = e_dump;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic setup(input int lim, input int st, input int sp, input bit ldi);
      @(negedge clock);
      reset = 1'b1;
      system_ready = 1'b0;
      ld_if.load_ack = 1'b0;
      cfg_cyclelimit = 8'(lim);
      cfg_startdump = 8'(st);
      cfg_stopdump = 8'(sp);
      cfg_load_imem = ldi;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_count(input int v);
      int n;
      n = 0;
      while ((int'(cycle_count) != v) && (n < 2000)) begin
         @(negedge clock);
         n++;
      end
      if (int'(cycle_count) != v) check("wait_count_timeout", 32'(cycle_count), 32'(v));
   endtask

   int hi, tg;

   initial begin
      ld_if.load_ack = 1'b0;

      // 1: no preload, settle timing, then saturation
      setup(NEV, NEV, NEV, 1'b0);
      check("rst_count", 32'(cycle_count), 32'd0);
      check("rst_state", 32'(run_state), 32'd0);
      wait_count(10); system_ready = 1'b1;
      wait_count(11); check("s1_settle_first", 32'(run_state), 32'd1);
      wait_count(14); check("s1_settle_last", 32'(run_state), 32'd1);
      wait_count(15); check("s1_run", 32'(run_state), 32'd3);
      check("s1_no_req", 32'(ld_if.load_req), 32'd0);
      wait_count(255);
      repeat (5) @(negedge clock);
      check("s1_saturate", 32'(cycle_count), 32'd255);
      $display("scenario 1 settle/saturate done, count=%0d", cycle_count);

      // 2: preload acked on the 7th request cycle
      setup(NEV, NEV, NEV, 1'b1);
      wait_count(10); system_ready = 1'b1;
      wait_count(15); check("s2_load", 32'(run_state), 32'd2);
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         if (ld_if.load_req) hi++;
         ld_if.load_ack = (int'(cycle_count) == 21);
         @(negedge clock);
      end
      check("s2_req_cycles", 32'(hi), 32'd7);
      check("s2_run", 32'(run_state), 32'd3);
      check("s2_no_err", 32'(load_err), 32'd0);
      $display("scenario 2 acked preload done, req cycles=%0d", hi);

      // 3: preload timeout
      setup(NEV, NEV, NEV, 1'b1);
      wait_count(10); system_ready = 1'b1;
      wait_count(15);
      hi = 0;
      for (int i = 0; i < 25; i++) begin
         if (ld_if.load_req) hi++;
         @(negedge clock);
      end
      check("s3_req_cycles", 32'(hi), 32'd16);
      check("s3_err", 32'(load_err), 32'd1);
      check("s3_run", 32'(run_state), 32'd3);
      $display("scenario 3 timeout done, req cycles=%0d", hi);

      // 4: dump window 100..200, then empty window 50..50
      setup(NEV, 100, 200, 1'b0);
      system_ready = 1'b1;
      tg = 0;
      for (int i = 0; i <= 210; i++) begin
         if (dump_toggle) tg++;
         if (i == 100) check("s4_dump_100", 32'(dump_on), 32'd0);
         if (i == 101) check("s4_dump_101", 32'(dump_on), 32'd1);
         if (i == 200) check("s4_dump_200", 32'(dump_on), 32'd1);
         if (i == 201) check("s4_dump_201", 32'(dump_on), 32'd0);
         @(negedge clock);
      end
      check("s4_toggles", 32'(tg), 32'd2);
      setup(NEV, 50, 50, 1'b0);
      system_ready = 1'b1;
      tg = 0;
      for (int i = 0; i < 80; i++) begin
         if (dump_toggle) tg++;
         @(negedge clock);
      end
      check("s4_empty_toggles", 32'(tg), 32'd0);
      $display("scenario 4 dump window done");

      // 5: cycle limit 150 inside an open window
      setup(150, 100, 200, 1'b0);
      system_ready = 1'b1;
      tg = 0;
      for (int i = 0; i <= 160; i++) begin
         if (dump_toggle) tg++;
         if (i == 150) begin
            check("s5_pre_finish", 32'(finish), 32'd0);
            check("s5_pre_dump", 32'(dump_on), 32'd1);
         end
         if (i == 151) begin
            check("s5_finish", 32'(finish), 32'd1);
            check("s5_done", 32'(run_state), 32'd4);
            check("s5_dump_off", 32'(dump_on), 32'd0);
            check("s5_toggle", 32'(dump_toggle), 32'd1);
         end
         @(negedge clock);
      end
      check("s5_frozen", 32'(cycle_count), 32'd150);
      check("s5_toggles", 32'(tg), 32'd2);
      $display("scenario 5 finish done, count=%0d", cycle_count);

      // 6: ready drop during load, late ack, then reset during run
      setup(NEV, NEV, NEV, 1'b1);
      wait_count(10); system_ready = 1'b1;
      wait_count(18); check("s6_req", 32'(ld_if.load_req), 32'd1);
      system_ready = 1'b0;
      @(negedge clock);
      check("s6_drop_req", 32'(ld_if.load_req), 32'd0);
      check("s6_drop_state", 32'(run_state), 32'd0);
      ld_if.load_ack = 1'b1;
      @(negedge clock);
      ld_if.load_ack = 1'b0;
      check("s6_late_ack_state", 32'(run_state), 32'd0);
      check("s6_late_ack_err", 32'(load_err), 32'd0);
      system_ready = 1'b1;
      wait_count(45); check("s6_run", 32'(run_state), 32'd3);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("s6_rst_count", 32'(cycle_count), 32'd0);
      check("s6_rst_state", 32'(run_state), 32'd0);
      check("s6_rst_err", 32'(load_err), 32'd0);
      check("s6_rst_req", 32'(ld_if.load_req), 32'd0);
      @(negedge clock);
      check("s6_restart", 32'(cycle_count), 32'd1);
      $display("scenario 6 drop/reset done");

      // 7: randomized configurations and handshakes
      for (int it = 0; it < 12; it++) begin
         int lim, st, sp;
         bit ldi;
         lim = ($urandom_range(0, 3) == 0) ? NEV : int'($urandom_range(20, 250));
         st  = ($urandom_range(0, 5) == 0) ? NEV : int'($urandom_range(0, 254));
         sp  = ($urandom_range(0, 5) == 0) ? NEV
             : (($urandom_range(0, 5) == 0) ? st : int'($urandom_range(0, 254)));
         ldi = 1'($urandom_range(0, 1));
         setup(lim, st, sp, ldi);
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 11) == 0) system_ready = ~system_ready;
            ld_if.load_ack = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 249) == 0);
            @(negedge clock);
         end
         reset = 1'b0;
         ld_if.load_ack = 1'b0;
         $display("random run %0d: limit=%0d start=%0d stop=%0d load=%0d", it, lim, st, sp, ldi);
      end

      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
